// File: rtl/debug_tube_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | debug_tube_scanner : selects a debug word, snapshots it once per frame,   |
// |                      and multiplexes its hex digits onto a 7-seg tube.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module debug_tube_scanner #(
  parameter int DIGITS         = 4,
  parameter int CHANNELS       = 8,
  parameter int SCAN_DIV       = 1024,
  parameter int AUTO_DIV       = 64,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_W          = $clog2(CHANNELS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*DIGITS*4-1:0]   chanData,
  input  logic [SEL_W-1:0]               sel,
  input  logic                           autoMode,
  input  logic                           freeze,
  input  logic [DIGITS-1:0]              dots,
  output logic [DIGITS-1:0]              tubeDig,
  output logic [7:0]                     tubeSeg,
  output logic [$clog2(CHANNELS)-1:0]    curChan
);

  localparam int CH_W   = $clog2(CHANNELS);
  localparam int PS_W   = $clog2(SCAN_DIV);
  localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW_W   = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
  localparam int WORD_W = DIGITS * 4;

  localparam logic [PS_W-1:0]   PS_MAX   = PS_W'(SCAN_DIV - 1);
  localparam logic [DIG_W-1:0]  DIG_MAX  = DIG_W'(DIGITS - 1);
  localparam logic [DW_W-1:0]   DW_MAX   = DW_W'(AUTO_DIV - 1);
  localparam logic [CH_W-1:0]   CH_MAX   = CH_W'(CHANNELS - 1);
  localparam logic [7:0]        SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] DIG_OFF  = (SEG_ACTIVE_LOW != 0) ? '1 : '0;

  logic [PS_W-1:0]   prescaler_q, prescaler_d;
  logic [DIG_W-1:0]  digIdx_q, digIdx_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic [CH_W-1:0]   curChan_q, curChan_d;
  logic [WORD_W-1:0] snap_q, snap_d;
  logic              lastAuto_q, lastAuto_d;
  logic [DIGITS-1:0] tubeDig_q, tubeDig_d;
  logic [7:0]        tubeSeg_q, tubeSeg_d;

  logic tick;
  logic frameEnd;

  assign tick     = (prescaler_q == PS_MAX);
  assign frameEnd = tick && (digIdx_q == DIG_MAX);

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    prescaler_d = tick ? '0 : prescaler_q + 1'b1;
    digIdx_d    = digIdx_q;
    dwell_d     = dwell_q;
    curChan_d   = curChan_q;
    snap_d      = snap_q;
    lastAuto_d  = lastAuto_q;

    if (tick) begin
      digIdx_d = (digIdx_q == DIG_MAX) ? '0 : digIdx_q + 1'b1;
    end

    if (frameEnd && !freeze) begin
      lastAuto_d = autoMode;
      if (autoMode) begin
        // Entering auto mode restarts the dwell count from the current channel.
        if (!lastAuto_q) begin
          dwell_d = '0;
        end else if (dwell_q == DW_MAX) begin
          dwell_d   = '0;
          curChan_d = (curChan_q == CH_MAX) ? '0 : curChan_q + 1'b1;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end else if (int'(sel) < CHANNELS) begin
        curChan_d = CH_W'(sel);
      end
      snap_d = chanData[int'(curChan_d) * WORD_W +: WORD_W];
    end
  end

  always_comb begin
    logic [7:0]        segLow;
    logic [DIGITS-1:0] digLow;
    segLow    = {~dots[digIdx_q], hex7(snap_q[int'(digIdx_q) * 4 +: 4])};
    digLow    = ~(DIGITS'(1) << digIdx_q);
    tubeSeg_d = (SEG_ACTIVE_LOW != 0) ? segLow : ~segLow;
    tubeDig_d = (SEG_ACTIVE_LOW != 0) ? digLow : ~digLow;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler_q <= '0;
      digIdx_q    <= '0;
      dwell_q     <= '0;
      curChan_q   <= '0;
      snap_q      <= '0;
      lastAuto_q  <= 1'b0;
      tubeDig_q   <= DIG_OFF;
      tubeSeg_q   <= SEG_OFF;
    end else begin
      prescaler_q <= prescaler_d;
      digIdx_q    <= digIdx_d;
      dwell_q     <= dwell_d;
      curChan_q   <= curChan_d;
      snap_q      <= snap_d;
      lastAuto_q  <= lastAuto_d;
      tubeDig_q   <= tubeDig_d;
      tubeSeg_q   <= tubeSeg_d;
    end
  end

  assign tubeDig = tubeDig_q;
  assign tubeSeg = tubeSeg_q;
  assign curChan = curChan_q;

endmodule
`default_nettype wire
